ground_probe: RTL and testbench

- Per-frame support/collision detector for the goose. It is the consumer end of the ground renderers' isGround output.
- It watches the pixel scan. When the scan hits the row directly under the goose's feet, it counts ground pixels there.
- At each frame boundary it decides whether the goose is standing, airborne or has fallen into a gap.
- Sits between the ORed ground-tile isGround outputs and the goose physics/game-state logic.

---
 rtl/ground_probe.sv | 216 +++++++++++++++++++++
 tb/tb_ground_probe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ground_probe.sv
// ---------------------------------------------------------------------------
// ground_probe
//
// Per-frame support / collision detector for the goose sprite. It watches
// the pixel scan and counts ground pixels on the row directly beneath the
// goose's feet. At every frame boundary it decides whether the goose is
// standing, airborne, or has sunk into a gap for long enough to have fallen.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   p_tick      in   pixel-rate enable (one clk per pixel)
//   video_on    in   scan is in the visible area
//   x, y        in   current scan column / row (10 bits each)
//   is_ground   in   OR of all ground-tile isGround outputs at (x,y)
//   frame_tick  in   one-clk pulse per frame, during vertical blank
//   goose_x/y   in   goose sprite top-left corner
//   clear       in   synchronous game restart (wins over frame_tick)
//   on_ground   out  goose supported as of the last decision
//   landed      out  one-clk pulse on AIR -> GROUND
//   fell        out  one-clk pulse on entering FALLEN
//   fallen      out  high while in FALLEN
//   hit_count   out  probe-row ground-pixel count of the last closed frame
// ---------------------------------------------------------------------------
module ground_probe #(
  parameter int GOOSE_W     = 32,
  parameter int GOOSE_H     = 32,
  parameter int MIN_HITS    = 8,
  parameter int GROUND_Y    = 385,
  parameter int MISS_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       is_ground,
  input  logic       frame_tick,
  input  logic [9:0] goose_x,
  input  logic [9:0] goose_y,
  input  logic       clear,
  output logic       on_ground,
  output logic       landed,
  output logic       fell,
  output logic       fallen,
  output logic [5:0] hit_count
);

  typedef enum logic [1:0] {
    ST_AIR    = 2'd0,
    ST_GROUND = 2'd1,
    ST_FALLEN = 2'd2
  } state_t;

  localparam logic [10:0] WIN_SPAN   = 11'(GOOSE_W - 1);
  localparam logic [10:0] PROBE_OFS  = 11'(GOOSE_H);
  localparam logic [10:0] LAST_ROW   = 11'd479;
  localparam logic [10:0] GROUND_ROW = 11'(GROUND_Y);
  localparam logic [5:0]  HIT_MIN    = 6'(MIN_HITS);
  localparam logic [5:0]  HIT_MAX    = 6'd63;
  localparam logic [2:0]  MISS_MAX   = 3'(MISS_FRAMES);

  // Saturating +1 for the hit counter.
  function automatic logic [5:0] sat_hit(input logic [5:0] v, input logic inc);
    logic [5:0] r;
    r = v;
    if (inc && (v != HIT_MAX)) begin
      r = v + 6'd1;
    end
    return r;
  endfunction

  // Saturating +1 for the miss counter; it never exceeds MISS_FRAMES.
  function automatic logic [2:0] sat_miss(input logic [2:0] v);
    logic [2:0] r;
    r = MISS_MAX;
    if (v < MISS_MAX) begin
      r = v + 3'd1;
    end
    return r;
  endfunction

  state_t     state_q,     state_d;
  logic [2:0] miss_q,      miss_d;
  logic [5:0] hit_cnt_q,   hit_cnt_d;
  logic [5:0] hit_count_q, hit_count_d;
  logic [9:0] gx_q,        gx_d;
  logic [9:0] gy_q,        gy_d;
  logic       landed_q,    landed_d;
  logic       fell_q,      fell_d;
  logic       on_ground_q, on_ground_d;
  logic       fallen_q,    fallen_d;

  logic [10:0] probe_row;
  logic [10:0] col_lo;
  logic [10:0] col_hi;
  logic        row_match;
  logic        col_match;
  logic        sample;
  logic [5:0]  hit_tot;
  logic        sup;
  logic        sunk;

  // Probe window, built only from the positions latched at the last frame
  // boundary so a mid-frame goose move cannot split the window across rows.
  // All arithmetic is 11 bits so nothing wraps back onto the visible area.
  always_comb begin
    probe_row = {1'b0, gy_q} + PROBE_OFS;
    col_lo    = {1'b0, gx_q};
    col_hi    = col_lo + WIN_SPAN;
    row_match = (probe_row <= LAST_ROW) && ({1'b0, y} == probe_row);
    col_match = ({1'b0, x} >= col_lo) && ({1'b0, x} <= col_hi);
    sample    = p_tick && video_on && is_ground && row_match && col_match;
    // A sample landing on the frame_tick clk still belongs to the closing frame.
    hit_tot   = sat_hit(hit_cnt_q, sample);
    sup       = (hit_tot >= HIT_MIN);
    sunk      = !sup && (probe_row > GROUND_ROW);
  end

  // Next-state / decision logic
  always_comb begin
    state_d     = state_q;
    miss_d      = miss_q;
    hit_cnt_d   = sat_hit(hit_cnt_q, sample);
    hit_count_d = hit_count_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    landed_d    = 1'b0;
    fell_d      = 1'b0;

    if (clear) begin
      state_d   = ST_AIR;
      miss_d    = 3'd0;
      hit_cnt_d = 6'd0;
    end else if (frame_tick) begin
      hit_count_d = hit_tot;
      hit_cnt_d   = 6'd0;
      gx_d        = goose_x;
      gy_d        = goose_y;
      case (state_q)
        ST_AIR: begin
          if (sup) begin
            state_d  = ST_GROUND;
            landed_d = 1'b1;
            miss_d   = 3'd0;
          end else if (sunk) begin
            miss_d = sat_miss(miss_q);
            if (sat_miss(miss_q) >= MISS_MAX) begin
              state_d = ST_FALLEN;
              fell_d  = 1'b1;
            end
          end else begin
            miss_d = 3'd0;
          end
        end
        ST_GROUND: begin
          if (!sup) begin
            state_d = ST_AIR;
            miss_d  = 3'd0;
            if (sunk) begin
              miss_d = 3'd1;
              if (3'd1 >= MISS_MAX) begin
                state_d = ST_FALLEN;
                fell_d  = 1'b1;
              end
            end
          end
        end
        ST_FALLEN: begin
          // Terminal until clear or reset; only hit_count keeps updating.
        end
        default: begin
          state_d = ST_AIR;
          miss_d  = 3'd0;
        end
      endcase
    end

    on_ground_d = (state_d == ST_GROUND);
    fallen_d    = (state_d == ST_FALLEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_AIR;
      miss_q      <= 3'd0;
      hit_cnt_q   <= 6'd0;
      hit_count_q <= 6'd0;
      gx_q        <= 10'd0;
      gy_q        <= 10'd0;
      landed_q    <= 1'b0;
      fell_q      <= 1'b0;
      on_ground_q <= 1'b0;
      fallen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_q      <= miss_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_count_q <= hit_count_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      landed_q    <= landed_d;
      fell_q      <= fell_d;
      on_ground_q <= on_ground_d;
      fallen_q    <= fallen_d;
    end
  end

  assign on_ground = on_ground_q;
  assign landed    = landed_q;
  assign fell      = fell_q;
  assign fallen    = fallen_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_ground_probe.sv
// ---------------------------------------------------------------------------
// tb_ground_probe
//
// Drives abbreviated frames (noise pixels, one or more sweeps of the probe
// row, then a frame_tick) into ground_probe and compares the frame decisions
// against a reference model computed from the ground map with plain counting.
// ---------------------------------------------------------------------------
module tb_ground_probe;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       is_ground;
  logic       frame_tick;
  logic [9:0] goose_x;
  logic [9:0] goose_y;
  logic       clear;
  logic       on_ground;
  logic       landed;
  logic       fell;
  logic       fallen;
  logic [5:0] hit_count;

  ground_probe #(
    .GOOSE_W(32), .GOOSE_H(32), .MIN_HITS(8), .GROUND_Y(385), .MISS_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .is_ground(is_ground), .frame_tick(frame_tick),
    .goose_x(goose_x), .goose_y(goose_y), .clear(clear),
    .on_ground(on_ground), .landed(landed), .fell(fell), .fallen(fallen),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  localparam int M_AIR  = 0;
  localparam int M_GND  = 1;
  localparam int M_FALL = 2;

  int ncmp = 0;
  int nerr = 0;

  // Ground map: row y is ground where y >= 385 and the column mask is set.
  bit colmask [640];

  // Reference model state
  int m_state, m_miss, m_hc, m_gx, m_gy;
  bit m_landed, m_fell;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit gnd(input int xx, input int yy);
    return (yy >= 385) && colmask[xx];
  endfunction

  // One pixel-clock; goose inputs wander mid-frame and must have no effect.
  task automatic px(input logic p, input logic v, input int xx, input int yy, input logic g);
    p_tick    = p;
    video_on  = v;
    x         = 10'(xx);
    y         = 10'(yy);
    is_ground = g;
    goose_x   = 10'($urandom_range(0, 639));
    goose_y   = 10'($urandom_range(0, 479));
    cyc();
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".on_ground"}, on_ground, (m_state == M_GND));
    chk({tag, ".fallen"},    fallen,    (m_state == M_FALL));
    chk({tag, ".landed"},    landed,    m_landed);
    chk({tag, ".fell"},      fell,      m_fell);
    chk({tag, ".hit_count"}, hit_count, m_hc);
  endtask

  task automatic set_mask(input int lo, input int hi);
    for (int i = 0; i < 640; i++) colmask[i] = (i >= lo) && (i <= hi);
  endtask

  // One frame with the currently latched goose position, then a frame_tick
  // presenting (ngx, ngy). tsamp moves the last in-window ground pixel onto
  // the frame_tick clk; passes sweeps the probe row several times.
  task automatic frame(input string tag, input int ngx, input int ngy,
                       input bit tsamp, input bit do_clr, input int passes);
    int pr, lo, hi, cnt, xl, hits, rowy, yy;
    bit sup, sunk;
    pr  = m_gy + 32;
    lo  = m_gx;
    hi  = (m_gx + 31 > 639) ? 639 : m_gx + 31;
    cnt = 0;
    xl  = -1;
    if (pr <= 479) begin
      for (int xx = lo; xx <= hi; xx++) begin
        if (gnd(xx, pr)) begin
          cnt++;
          xl = xx;
        end
      end
    end
    hits = passes * cnt;
    if (hits > 63) hits = 63;
    rowy = (pr <= 479) ? pr : $urandom_range(0, 479);

    // Off-row noise and a blanked probe-row pixel: none of these may count.
    for (int n = 0; n < 20; n++) begin
      yy = $urandom_range(0, 479);
      if (yy == pr) yy = (yy + 1) % 480;
      px(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom_range(0, 639), yy, 1'($urandom_range(0, 1)));
    end
    if (pr <= 479) px(1'b1, 1'b0, lo, pr, 1'b1);

    for (int p = 0; p < passes; p++) begin
      for (int xx = 0; xx < 640; xx++) begin
        if ($urandom_range(0, 7) == 0) px(1'b0, 1'b1, xx, rowy, 1'b1);
        if (!(tsamp && xl >= 0 && p == passes - 1 && xx == xl)) begin
          px(1'b1, 1'b1, xx, rowy, gnd(xx, rowy));
        end
      end
    end

    frame_tick = 1'b1;
    clear      = do_clr;
    goose_x    = 10'(ngx);
    goose_y    = 10'(ngy);
    if (tsamp && xl >= 0) begin
      p_tick = 1'b1; video_on = 1'b1; x = 10'(xl); y = 10'(pr); is_ground = 1'b1;
    end else begin
      p_tick = 1'b0; video_on = 1'b1; x = 10'(lo); y = 10'(rowy); is_ground = 1'b1;
    end
    cyc();
    frame_tick = 1'b0;
    clear      = 1'b0;

    m_landed = 1'b0;
    m_fell   = 1'b0;
    if (do_clr) begin
      m_state = M_AIR;
      m_miss  = 0;
    end else begin
      m_hc = hits;
      m_gx = ngx;
      m_gy = ngy;
      sup  = (hits >= 8);
      sunk = !sup && (pr > 385);
      if (m_state == M_AIR) begin
        if (sup) begin
          m_state = M_GND; m_landed = 1'b1; m_miss = 0;
        end else if (sunk) begin
          m_miss = (m_miss + 1 > 2) ? 2 : m_miss + 1;
          if (m_miss >= 2) begin
            m_state = M_FALL; m_fell = 1'b1;
          end
        end else begin
          m_miss = 0;
        end
      end else if (m_state == M_GND) begin
        if (!sup) begin
          m_state = M_AIR;
          m_miss  = sunk ? 1 : 0;
        end
      end
    end
    check_outs(tag);

    px(1'b0, 1'b0, 0, 0, 1'b0);
    m_landed = 1'b0;
    m_fell   = 1'b0;
    check_outs({tag, ".after"});
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
    is_ground = 1'b0; frame_tick = 1'b0; clear = 1'b0;
    goose_x = '0; goose_y = '0;
    m_state = M_AIR; m_miss = 0; m_hc = 0; m_gx = 0; m_gy = 0;
    m_landed = 1'b0; m_fell = 1'b0;
    repeat (3) cyc();
    check_outs("reset");
    reset = 1'b0;
    cyc();

    // Full ground, goose standing on row 385.
    set_mask(0, 639);
    frame("boot", 100, 353, 1'b0, 1'b0, 1);
    frame("land", 100, 353, 1'b0, 1'b0, 1);
    frame("stand", 100, 353, 1'b0, 1'b0, 1);

    // Narrow gap: 6 hits, lift off but not sunk; then move down to pr=392.
    set_mask(100, 105);
    frame("gap", 100, 360, 1'b0, 1'b0, 1);

    // Sunk twice -> fall; later support is ignored while fallen.
    set_mask(0, -1);
    frame("sink1", 100, 360, 1'b0, 1'b0, 1);
    frame("sink2", 100, 360, 1'b0, 1'b0, 1);
    set_mask(0, 639);
    frame("fallen_sup", 100, 360, 1'b0, 1'b0, 1);

    // clear together with frame_tick: clear wins, position not relatched.
    frame("clear", 100, 353, 1'b0, 1'b1, 1);
    frame("reland", 100, 353, 1'b0, 1'b0, 1);

    // Two sweeps without a tick saturate the count; then right-edge clip.
    frame("saturate", 620, 353, 1'b0, 1'b0, 2);
    frame("clip", 100, 460, 1'b0, 1'b0, 1);
    frame("offscreen", 100, 353, 1'b0, 1'b0, 1);

    // Eighth hit arrives on the frame_tick clk itself.
    set_mask(100, 107);
    frame("tick_sample", 100, 353, 1'b1, 1'b0, 1);

    // Randomized frames.
    for (int r = 0; r < 14; r++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 640; i++) colmask[i] = ($urandom_range(0, 99) < dens);
      frame("rand", $urandom_range(0, 639), $urandom_range(330, 470),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1);
    end

    // Get into GROUND at pr=385, then reset mid-scan after 20 hits.
    set_mask(0, 639);
    frame("pre_clr", 100, 353, 1'b0, 1'b1, 1);
    frame("pre_lat", 100, 353, 1'b0, 1'b0, 1);
    frame("pre_gnd", 100, 353, 1'b0, 1'b0, 1);
    chk("pre_reset.state_ground", on_ground, 1'b1);
    for (int xx = 100; xx < 120; xx++) px(1'b1, 1'b1, xx, 385, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    m_state = M_AIR; m_miss = 0; m_hc = 0; m_gx = 0; m_gy = 0;
    m_landed = 1'b0; m_fell = 1'b0;
    check_outs("async_reset");
    cyc();
    reset = 1'b0;
    frame("post_reset", 100, 353, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
